// File: rtl/apb3_regfile_completer_pkg.sv
// Shared APB3 types and helpers used by the Renode co-simulation requester and completer.
package apb3_regfile_completer_pkg;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_SETUP,
    R_ACCESS
  } req_state_t;

  function automatic int unsigned byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb3_regfile_completer.sv
// APB3 completer: small register file with programmable wait states and
// pslverr on misaligned or out-of-range accesses.
module apb3_regfile_completer
  import apb3_regfile_completer_pkg::*;
#(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned RegCount     = 8,
  parameter int unsigned WaitStates   = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DataWidth-1:0]    pwdata,
  output logic                    pready,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pslverr
);

  localparam int unsigned ByteLanes = byte_lanes(DataWidth);
  localparam int unsigned OffW      = $clog2(ByteLanes);
  localparam int unsigned IdxW      = (RegCount > 1) ? $clog2(RegCount) : 1;
  localparam logic [AddressWidth-1:0] OffMask  = AddressWidth'(ByteLanes - 1);
  localparam logic [AddressWidth-1:0] RegLimit = AddressWidth'(RegCount);
  localparam logic [3:0]              WaitInit = 4'(WaitStates);

  if (!(DataWidth == 8 || DataWidth == 16 || DataWidth == 32 || DataWidth == 64)) begin : g_bad_dw
    $error("apb3_regfile_completer: DataWidth must be 8, 16, 32 or 64");
  end
  if (RegCount < 1 || RegCount > 256) begin : g_bad_rc
    $error("apb3_regfile_completer: RegCount must be 1..256");
  end
  if (WaitStates > 15) begin : g_bad_ws
    $error("apb3_regfile_completer: WaitStates must be 0..15");
  end

  state_t                  state, state_next;
  logic [3:0]              wait_cnt;
  logic [IdxW-1:0]         idx_q;
  logic                    write_q;
  logic [DataWidth-1:0]    wdata_q;
  logic                    err_q;
  logic [DataWidth-1:0]    regs [RegCount];

  logic [AddressWidth-1:0] word_addr;
  logic                    setup_err;
  logic                    setup;

  // Range check uses the full word address so upper paddr bits never alias.
  assign word_addr = paddr >> OffW;
  assign setup_err = ((paddr & OffMask) != '0) || (word_addr >= RegLimit);
  assign setup     = (state == S_IDLE) && pselx && !penable;

  always_comb begin
    state_next = state;
    pready     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (setup) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        pready = (wait_cnt == '0) && pselx && penable;
        if (!pselx || pready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (setup) begin
        idx_q    <= IdxW'(word_addr);
        write_q  <= pwrite;
        wdata_q  <= pwdata;
        err_q    <= setup_err;
        wait_cnt <= WaitInit;
      end else if (state == S_ACCESS && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < RegCount; i++) regs[i] <= '0;
    end else if (pready && write_q && !err_q) begin
      regs[idx_q] <= wdata_q;
    end
  end

  assign prdata  = (pready && !err_q) ? regs[idx_q] : '0;
  assign pslverr = pready && err_q;

endmodule

// File: tb/tb_apb3_regfile_completer.sv
// Directed self-checking bench for apb3_regfile_completer (WaitStates=2 and WaitStates=0 instances).
module tb_apb3_regfile_completer;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [19:0] paddr;
  logic        pselx2, pselx0;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready2, pready0;
  logic [31:0] prdata2, prdata0;
  logic        pslverr2, pslverr0;

  logic        use0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 pclk = ~pclk;

  apb3_regfile_completer #(
    .AddressWidth(20), .DataWidth(32), .RegCount(8), .WaitStates(2)
  ) dut2 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(pselx2),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready2), .prdata(prdata2), .pslverr(pslverr2)
  );

  apb3_regfile_completer #(
    .AddressWidth(20), .DataWidth(32), .RegCount(8), .WaitStates(0)
  ) dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pselx(pselx0),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  task automatic set_sel(input logic v);
    if (use0) pselx0 = v;
    else      pselx2 = v;
  endtask

  // Starts at posedge+1; returns at posedge+1 right after the completion edge
  // with the bus idle, so a following call is a back-to-back setup.
  task automatic apb_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] data,
                          output int acc, output logic [31:0] rd, output logic err);
    logic rdy;
    acc = 0; rd = 'x; err = 1'bx;
    set_sel(1'b1); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    pwdata  = ~data;
    paddr   = addr ^ 20'h4;
    forever begin
      @(negedge pclk);
      acc++;
      rdy = use0 ? pready0 : pready2;
      if (rdy === 1'b1) begin
        rd  = use0 ? prdata0 : prdata2;
        err = use0 ? pslverr0 : pslverr2;
        break;
      end
      if (acc > 20) begin
        n_tests++; n_fail++;
        $display("FAIL timeout addr=%h: no pready after %0d access cycles", addr, acc);
        break;
      end
    end
    @(posedge pclk); #1;
    set_sel(1'b0); penable = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge pclk); #1;
  endtask

  task automatic test_reset();
    int acc; logic [31:0] rd; logic err;
    use0 = 1'b0;
    @(negedge pclk);
    n_tests++;
    if ({pready2, prdata2, pslverr2, pready0, prdata0, pslverr0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy2=%b rd2=%h err2=%b rdy0=%b rd0=%h err0=%b, want all 0",
               pready2, prdata2, pslverr2, pready0, prdata0, pslverr0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle_cycle();
    apb_xfer(1'b0, 20'h8, 32'h0, acc, rd, err);
    n_tests++;
    if (acc !== 3) begin n_fail++; $display("FAIL reset_read_latency: got %0d access cycles, want 3", acc); end
    n_tests++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_read_data: got %h, want 00000000", rd); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_read_err: got %b, want 0", err); end
  endtask

  task automatic test_write_read();
    int acc; logic [31:0] rd; logic err;
    use0 = 1'b0;
    idle_cycle();
    apb_xfer(1'b1, 20'h4, 32'hDEADBEEF, acc, rd, err);
    n_tests++;
    if (acc !== 3 || err !== 1'b0) begin
      n_fail++; $display("FAIL write_4: got acc=%0d err=%b, want acc=3 err=0", acc, err);
    end
    idle_cycle();
    apb_xfer(1'b0, 20'h4, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL read_4: got %h err=%b, want deadbeef err=0", rd, err);
    end
    idle_cycle();
    apb_xfer(1'b0, 20'h0, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL read_0: got %h err=%b, want 00000000 err=0", rd, err);
    end
  endtask

  task automatic test_errors();
    int acc; logic [31:0] rd; logic err;
    logic [31:0] expv [8];
    expv = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    use0 = 1'b0;
    idle_cycle();
    apb_xfer(1'b0, 20'h20, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL read_oor_20: got %h err=%b, want 00000000 err=1", rd, err);
    end
    idle_cycle();
    apb_xfer(1'b0, 20'h6, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL read_misaligned_6: got %h err=%b, want 00000000 err=1", rd, err);
    end
    idle_cycle();
    apb_xfer(1'b0, 20'h80004, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_fail++; $display("FAIL read_alias_80004: got %h err=%b, want 00000000 err=1", rd, err);
    end
    idle_cycle();
    apb_xfer(1'b1, 20'h20, 32'h1234, acc, rd, err);
    n_tests++;
    if (err !== 1'b1 || acc !== 3) begin
      n_fail++; $display("FAIL write_oor_20: got err=%b acc=%0d, want err=1 acc=3", err, acc);
    end
    for (int i = 0; i < 8; i++) begin
      idle_cycle();
      apb_xfer(1'b0, 20'(i * 4), 32'h0, acc, rd, err);
      n_tests++;
      if (rd !== expv[i] || err !== 1'b0) begin
        n_fail++; $display("FAIL regs_unchanged[%0d]: got %h err=%b, want %h err=0", i, rd, err, expv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc; logic [31:0] rd; logic err;
    use0 = 1'b1;
    idle_cycle();
    apb_xfer(1'b1, 20'h0, 32'h11, acc, rd, err);
    n_tests++;
    if (acc !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_write_0: got acc=%0d err=%b, want acc=1 err=0", acc, err);
    end
    apb_xfer(1'b1, 20'h1C, 32'h22, acc, rd, err);
    n_tests++;
    if (acc !== 1 || err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_write_1c: got acc=%0d err=%b, want acc=1 err=0", acc, err);
    end
    apb_xfer(1'b0, 20'h1C, 32'h0, acc, rd, err);
    n_tests++;
    if (acc !== 1 || rd !== 32'h22 || err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_read_1c: got acc=%0d data=%h err=%b, want acc=1 data=00000022 err=0", acc, rd, err);
    end
    apb_xfer(1'b0, 20'h0, 32'h0, acc, rd, err);
    n_tests++;
    if (acc !== 1 || rd !== 32'h11) begin
      n_fail++; $display("FAIL b2b_read_0: got acc=%0d data=%h, want acc=1 data=00000011", acc, rd);
    end
  endtask

  task automatic test_abort_and_idle();
    int acc; logic [31:0] rd; logic err;
    use0 = 1'b0;
    idle_cycle();
    set_sel(1'b1); penable = 1'b0; pwrite = 1'b1; paddr = 20'h10; pwdata = 32'h99;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    n_tests++;
    if (pready2 !== 1'b0) begin n_fail++; $display("FAIL abort_wait_pready: got %b, want 0", pready2); end
    #1;
    set_sel(1'b0); penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_tests++;
      if (pready2 !== 1'b0) begin n_fail++; $display("FAIL abort_after_pready[%0d]: got %b, want 0", i, pready2); end
    end
    @(posedge pclk); #1;
    set_sel(1'b1); penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      n_tests++;
      if (pready2 !== 1'b0) begin n_fail++; $display("FAIL idle_violation_pready[%0d]: got %b, want 0", i, pready2); end
    end
    @(posedge pclk); #1;
    set_sel(1'b0); penable = 1'b0;
    idle_cycle();
    apb_xfer(1'b0, 20'h10, 32'h0, acc, rd, err);
    n_tests++;
    if (acc !== 3 || rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL abort_read_10: got acc=%0d data=%h err=%b, want acc=3 data=00000000 err=0", acc, rd, err);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int acc; logic [31:0] rd; logic err;
    use0 = 1'b0;
    idle_cycle();
    set_sel(1'b1); penable = 1'b0; pwrite = 1'b1; paddr = 20'hC; pwdata = 32'h55;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    n_tests++;
    if ({pready2, prdata2, pslverr2} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got rdy=%b data=%h err=%b, want 0", pready2, prdata2, pslverr2);
    end
    set_sel(1'b0); penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle_cycle();
    apb_xfer(1'b0, 20'hC, 32'h0, acc, rd, err);
    n_tests++;
    if (acc !== 3 || rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_read_c: got acc=%0d data=%h err=%b, want acc=3 data=00000000 err=0", acc, rd, err);
    end
    idle_cycle();
    apb_xfer(1'b0, 20'h4, 32'h0, acc, rd, err);
    n_tests++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL midreset_read_4: got %h, want 00000000", rd);
    end
  endtask

  initial begin
    presetn = 1'b0; pselx2 = 1'b0; pselx0 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; use0 = 1'b0;
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_abort_and_idle();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb3_regfile_completer.md
# apb3_regfile_completer

APB3 completer that terminates transfers issued by the Renode-driven APB3 requester. It implements a small read/write register file with a programmable number of wait states. It flags misaligned or out-of-range accesses with `pslverr`. It is the downstream stage on the APB3 bus and gives co-simulation tests a deterministic target that is independent of any user peripheral.

## Interface
Parameters:
- `AddressWidth`, 20: width of `paddr`.
- `DataWidth`, 32: width of `pwdata`/`prdata`; must be 8, 16, 32 or 64.
- `RegCount`, 8: number of `DataWidth`-wide registers; 1..256.
- `WaitStates`, 0: cycles `pready` is held low in the access phase; 0..15.

Ports:
- `pclk` in 1: the single clock.
- `presetn` in 1: asynchronous, active-low reset.
- `paddr` in AddressWidth: byte address.
- `pselx` in 1: select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in DataWidth: write data.
- `pready` out 1: transfer completes this cycle.
- `prdata` out DataWidth: read data; valid only while `pready`.
- `pslverr` out 1: error response; valid only while `pready`.

## Operation
- Definitions:
  - ByteLanes = DataWidth/8.
  - index = paddr >> log2(ByteLanes).
  - misaligned = paddr[log2(ByteLanes)-1:0] != 0.
  - out_of_range = index >= RegCount.
  - err = misaligned | out_of_range.
- State machine `S_IDLE`, `S_ACCESS`:
  - `S_IDLE`: on `pselx && !penable` (setup phase), latch index, `pwrite`, `pwdata` and err. Load `wait_cnt` = WaitStates. Go to `S_ACCESS`. `pselx && penable` seen in `S_IDLE` is a protocol violation: ignore it and stay in `S_IDLE`.
  - `S_ACCESS`: while `wait_cnt` != 0, decrement it each cycle. `pready` = (`wait_cnt` == 0) && `pselx` && `penable`. Completion is the rising edge with `pready` = 1: go to `S_IDLE`.
  - If `pselx` drops in `S_ACCESS` before completion: abort, return to `S_IDLE`, no register update.
- Write: at the completion edge, if !err, `regs[index]` <= latched `pwdata`. Erroneous writes change nothing.
- Read: while `pready`, `prdata` = err ? 0 : `regs[index]`. Otherwise `prdata` = 0.
- `pslverr` = `pready` && err. It is 0 in all other cycles.
- Reset (asynchronous, any time, including mid-transfer):
  - state = `S_IDLE`, `wait_cnt` = 0, all regs = 0.
  - `pready` = 0, `prdata` = 0, `pslverr` = 0.
  - An in-flight write is discarded.
- Width rules:
  - index is truncated to log2(RegCount) bits only after the out_of_range check.
  - Upper `paddr` bits always participate in the range check; no aliasing.

## Timing
- Setup cycle (cycle N), access cycle (N+1) onward. `pready` rises in cycle N+1+WaitStates.
- Zero-wait-state transfer therefore takes 2 cycles.
- Outputs are combinational from registered state and bus inputs. No combinational path from `pwdata` to `prdata`.
- Back-to-back: the requester returning to setup in the cycle after completion is accepted with no bubble. The completer is in `S_IDLE` at that edge.
- Register write data is visible to a read whose setup phase is in the cycle after write completion.
- `pwdata`/`paddr` changes during the access phase are ignored; latched setup values are used.

## Structure
- `state_t` (`S_IDLE`, `S_ACCESS`) and a `byte_lanes(DataWidth)` helper function go in the shared APB3 package, alongside the requester's state type.
- Register array, latch registers and `wait_cnt` (4 bits) stay inline.
- No sub-module.
- Parameter legality (DataWidth, RegCount, WaitStates ranges) is checked by elaboration-time assertions.

## Test plan
Configuration: DataWidth=32, RegCount=8, WaitStates=2 unless stated.
- Reset then read 0x8 -> `pready` in 3rd access cycle (4 cycles total), `prdata`=0x00000000, `pslverr`=0.
- Write 0xDEADBEEF to 0x4, then read 0x4 -> `prdata`=0xDEADBEEF, `pslverr`=0. Read 0x0 -> 0x0.
- Read 0x20 (index 8) and read 0x6 (misaligned) -> `pslverr`=1, `prdata`=0. Write 0x20 with 0x1234 -> `pslverr`=1, all regs unchanged.
- WaitStates=0: back-to-back write 0x0=0x11, write 0x1C=0x22, read 0x1C, with no idle gap -> each completes in 2 cycles, read returns 0x22.
- Assert `presetn` low during the access phase of write 0xC=0x55 -> outputs 0 immediately, later read 0xC returns 0.
- Drop `pselx` during the wait states of write 0x10=0x99 -> no `pready`, read 0x10 returns 0. `pselx&&penable` while idle -> `pready` stays 0.
